// File: rtl/alu_result_fifo.sv
// Result FIFO behind the sign-magnitude ALU: converts results to two's complement and buffers them.
// Optional ALU_FLAG_STATS_EN adds saturating negative/zero result counters with a synchronous clear.
module alu_result_fifo #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_r,
    input  logic          in_sf,
    input  logic          in_zf,
    input  logic          in_dzf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_data,
    output logic [2:0]    out_flags,
    output logic [CW-1:0] count,
    output logic          ovf_err
`ifdef ALU_FLAG_STATS_EN
    ,
    input  logic          stats_clr,
    output logic [7:0]    neg_cnt,
    output logic [7:0]    zero_cnt
`endif
);

    logic [3:0]    r_mem_data  [DEPTH];
    logic [2:0]    r_mem_flags [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf_err;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [2:0]    w_mag;
    logic          w_sf;
    logic          w_zf;
    logic [3:0]    w_data;
    logic          w_flag_mismatch;

    // Negative zero collapses to +0, so sign is only set for a non-zero magnitude
    assign w_mag  = in_r[2:0];
    assign w_zf   = (w_mag == 3'd0);
    assign w_sf   = in_r[3] && !w_zf;
    assign w_data = w_sf ? (4'd0 - {1'b0, w_mag}) : {1'b0, w_mag};

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = r_mem_data[r_rd_ptr];
    assign out_flags = r_mem_flags[r_rd_ptr];
    assign count     = r_count;
    assign ovf_err   = r_ovf_err;

    // Upstream flags are advisory; a disagreement is only observable as a coverage event
    assign w_flag_mismatch = (in_sf != w_sf) || (in_zf != w_zf);
    cover property (@(posedge clk) disable iff (!rst_n) w_push && w_flag_mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_data[i]  <= 4'd0;
                r_mem_flags[i] <= 3'd0;
            end
        end else if (w_push) begin
            r_mem_data[r_wr_ptr]  <= w_data;
            r_mem_flags[r_wr_ptr] <= {in_dzf, w_sf, w_zf};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (in_valid && w_full) r_ovf_err <= 1'b1;
        end
    end

`ifdef ALU_FLAG_STATS_EN
    logic [7:0] r_neg_cnt;
    logic [7:0] r_zero_cnt;

    assign neg_cnt  = r_neg_cnt;
    assign zero_cnt = r_zero_cnt;

    // Saturating counters of stored flags; clear has priority over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_cnt  <= 8'd0;
            r_zero_cnt <= 8'd0;
        end else if (stats_clr) begin
            r_neg_cnt  <= 8'd0;
            r_zero_cnt <= 8'd0;
        end else if (w_push) begin
            if (w_sf && (r_neg_cnt != 8'hFF))  r_neg_cnt  <= r_neg_cnt + 8'd1;
            if (w_zf && (r_zero_cnt != 8'hFF)) r_zero_cnt <= r_zero_cnt + 8'd1;
        end
    end
`endif

endmodule
